table_port_arb: RTL and testbench
=================================

TABLE_PORT_ARB -- requirements
Module: table_port_arb

Interface
REQ-001 SHALL have parameters:
- DEPTH, 256, table words (power of two, >=2)
- AW, 8, address width, log2(DEPTH)
- DW, 32, data width
REQ-002 SHALL have ports (name, direction, width, meaning):
- clk  in  1  sole clock
- rst_n  in  1  reset, asynchronous, active-low
- init_start  in  1  pulse; re-clear whole table
- init_busy  out  1  clear sequence in progress
- r0_req  in  1  requester 0 access request, held until granted
- r0_we  in  1  1=write, 0=read
- r0_addr  in  AW  address
- r0_wdata  in  DW  write data
- r0_gnt  out  1  request accepted this cycle
- r0_rvalid  out  1  read data valid
- r0_rdata  out  DW  read data
- r1_req, r1_we, r1_addr, r1_wdata, r1_gnt, r1_rvalid, r1_rdata: same as r0_* for requester 1
- mem_en  out  1  memory port enable
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, valid one cycle after mem_en && !mem_we
REQ-003 SHALL use one clock (clk) and asynchronous active-low reset (rst_n) for all state.

Function
REQ-004 SHALL implement FSM states INIT and ARB.
REQ-005 In INIT, counter c SHALL step 0..DEPTH-1, one per cycle, issuing a write of zero to address c; state SHALL go to ARB the cycle after c=DEPTH-1.
REQ-006 init_busy SHALL equal (state==INIT); r0_gnt and r1_gnt SHALL be 0 in INIT.
REQ-007 In ARB, init_start=1 SHALL move the state to INIT with c=0 on the next cycle; a grant in that same cycle SHALL still be issued and completed.
REQ-008 init_start during INIT SHALL be ignored; the counter SHALL not restart.
REQ-009 In ARB, rK_gnt SHALL be combinational in the same cycle as rK_req, at most one grant per cycle.
REQ-010 Arbitration:
- only one requester requesting: grant it
- both requesting: grant the requester not granted last
- a 1-bit last-grant pointer SHALL update only on a grant
REQ-011 mem_en/mem_we/mem_addr/mem_wdata SHALL be registered: a grant (or INIT step) in cycle N drives the memory command in cycle N+1; idle cycles drive mem_en=0.
REQ-012 A read granted in cycle N SHALL assert rK_rvalid for exactly one cycle in N+2, with rK_rdata=mem_rdata; writes SHALL produce no rvalid.
REQ-013 Read return SHALL use a 2-stage requester-tag pipeline independent of FSM state, so reads in flight at INIT entry still return.
REQ-014 rK_rdata SHALL be driven from mem_rdata at all times; it is meaningful only when rK_rvalid=1.
REQ-015 Sustained back-to-back grants SHALL reach one access per cycle with no bubbles.

Reset
REQ-016 While rst_n=0: state=INIT, c=0, last-grant pointer=1 (r0 wins first tie), mem_en=mem_we=0, mem_addr=0, mem_wdata=0, tag pipeline empty, rvalid outputs 0, init_busy=1.
REQ-017 After rst_n release, the first INIT write SHALL appear on the memory port the next cycle; init_busy SHALL deassert DEPTH cycles after release.
REQ-018 rst_n assertion mid-operation SHALL abort in-flight reads (no rvalid) and restart the clear from address 0.

Verification (DEPTH=8)
REQ-019 Reset release -> 8 consecutive writes, addr 0..7, data 0; init_busy drops after the 8th; no grants meanwhile.
REQ-020 r0 read addr 3 after r1 wrote 0xA5A5A5A5 to addr 3 -> r0_rvalid two cycles after r0_gnt, r0_rdata=0xA5A5A5A5.
REQ-021 r0 and r1 requesting continuously -> grants alternate r0,r1,r0,...; mem_en high every cycle.
REQ-022 init_start together with granted r1 read -> r1 read completes with rvalid, then 8 zero-writes; init_start repeated mid-INIT -> still exactly 8 writes.
REQ-023 rst_n pulsed low while r0 read in flight -> no r0_rvalid; clear restarts at addr 0.

Source files
------------

// File: rtl/table_port_arb.sv
// table_port_arb
//   Two-requester arbiter in front of a single-port table memory, with a
//   built-in clear sequence that writes zero to every word after reset or
//   on request.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_INIT | clearing: one zero-write per cycle to address cnt, no grants
// ARB     | serving r0/r1, tie goes to the requester not granted last
//
// Ports
//   clk, rst_n                  clock, async active-low reset
//   init_start / init_busy      clear request pulse / clear in progress
//   rK_req/we/addr/wdata        requester K command (held until rK_gnt)
//   rK_gnt                      combinational accept in the request cycle
//   rK_rvalid/rdata             read return two cycles after the grant
//   mem_en/we/addr/wdata        registered memory command
//   mem_rdata                   memory read data, one cycle after the read
module table_port_arb #(
    parameter int DEPTH = 256,
    parameter int AW    = 8,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          init_start,
    output logic          init_busy,
    input  logic          r0_req,
    input  logic          r0_we,
    input  logic [AW-1:0] r0_addr,
    input  logic [DW-1:0] r0_wdata,
    output logic          r0_gnt,
    output logic          r0_rvalid,
    output logic [DW-1:0] r0_rdata,
    input  logic          r1_req,
    input  logic          r1_we,
    input  logic [AW-1:0] r1_addr,
    input  logic [DW-1:0] r1_wdata,
    output logic          r1_gnt,
    output logic          r1_rvalid,
    output logic [DW-1:0] r1_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_ARB  = 1'b1
    } state_t;

    localparam logic [AW-1:0] CNT_LAST = AW'(DEPTH - 1);

    state_t        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    // 1 = r1 was granted last, so r0 wins the next tie.
    logic          last_q, last_d;
    logic          mem_en_q, mem_en_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    // Read-tag pipeline: stage 1 marks the cycle the memory sees the read,
    // stage 2 (rvalid) marks the cycle its data is on mem_rdata.
    logic          rd0_s1_q, rd0_s1_d;
    logic          rd1_s1_q, rd1_s1_d;
    logic          r0_rvalid_q, r0_rvalid_d;
    logic          r1_rvalid_q, r1_rvalid_d;

    logic          gnt0, gnt1;

    always_comb begin
        gnt0 = (state_q == ST_ARB) && r0_req && (!r1_req || last_q);
        gnt1 = (state_q == ST_ARB) && r1_req && (!r0_req || !last_q);
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_d      = last_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        // The tag pipeline runs regardless of state so reads granted in the
        // cycle that init_start is taken still return.
        rd0_s1_d    = gnt0 && !r0_we;
        rd1_s1_d    = gnt1 && !r1_we;
        r0_rvalid_d = rd0_s1_q;
        r1_rvalid_d = rd1_s1_q;

        case (state_q)
            ST_INIT: begin
                mem_en_d    = 1'b1;
                mem_we_d    = 1'b1;
                mem_addr_d  = cnt_q;
                mem_wdata_d = '0;
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_ARB;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + AW'(1);
                end
            end
            ST_ARB: begin
                if (gnt0) begin
                    mem_en_d    = 1'b1;
                    mem_we_d    = r0_we;
                    mem_addr_d  = r0_addr;
                    mem_wdata_d = r0_wdata;
                    last_d      = 1'b0;
                end else if (gnt1) begin
                    mem_en_d    = 1'b1;
                    mem_we_d    = r1_we;
                    mem_addr_d  = r1_addr;
                    mem_wdata_d = r1_wdata;
                    last_d      = 1'b1;
                end
                if (init_start) begin
                    state_d = ST_INIT;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_INIT;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_INIT;
            cnt_q       <= '0;
            last_q      <= 1'b1;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rd0_s1_q    <= 1'b0;
            rd1_s1_q    <= 1'b0;
            r0_rvalid_q <= 1'b0;
            r1_rvalid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rd0_s1_q    <= rd0_s1_d;
            rd1_s1_q    <= rd1_s1_d;
            r0_rvalid_q <= r0_rvalid_d;
            r1_rvalid_q <= r1_rvalid_d;
        end
    end

    assign init_busy = (state_q == ST_INIT);
    assign r0_gnt    = gnt0;
    assign r1_gnt    = gnt1;
    assign r0_rvalid = r0_rvalid_q;
    assign r1_rvalid = r1_rvalid_q;
    assign r0_rdata  = mem_rdata;
    assign r1_rdata  = mem_rdata;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_table_port_arb.sv
// Bench for table_port_arb with DEPTH=8: a table memory model, a
// transaction-level reference (table contents, busy/clear progress,
// last-grant rule, scheduled read returns) checked every cycle, and
// directed scenarios with literal expectations.
module tb_table_port_arb;
    localparam int DEPTH = 8;
    localparam int AW    = 3;
    localparam int DW    = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          init_start = 1'b0;
    logic          init_busy;
    logic          r0_req = 1'b0, r0_we = 1'b0;
    logic [AW-1:0] r0_addr = '0;
    logic [DW-1:0] r0_wdata = '0;
    logic          r0_gnt, r0_rvalid;
    logic [DW-1:0] r0_rdata;
    logic          r1_req = 1'b0, r1_we = 1'b0;
    logic [AW-1:0] r1_addr = '0;
    logic [DW-1:0] r1_wdata = '0;
    logic          r1_gnt, r1_rvalid;
    logic [DW-1:0] r1_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;

    always #5 clk = ~clk;

    table_port_arb #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n), .init_start(init_start), .init_busy(init_busy),
        .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
        .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Table memory attached to the port.
    logic [DW-1:0] bmem [DEPTH];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) bmem[mem_addr] <= mem_wdata;
            else        mem_rdata      <= bmem[mem_addr];
        end
    end

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model state.
    typedef struct {
        int            due;
        int            who;
        logic [DW-1:0] data;
    } ev_t;
    ev_t           evq[$];
    bit            m_busy = 1'b1;
    int            m_cnt  = 0;
    bit            m_last = 1'b1;
    bit            e_en = 1'b0, e_we = 1'b0;
    logic [AW-1:0] e_addr = '0;
    logic [DW-1:0] e_wdata = '0;
    logic [DW-1:0] m_tab [DEPTH];

    // Observation logs for the literal checks.
    int            wr_cnt = 0;
    logic [7:0]    wr_mask = '0;
    int            first_wr = -1;
    int            rv0_cnt = 0, rv1_cnt = 0, rv0_cyc = 0, rv1_cyc = 0;
    logic [DW-1:0] rv0_data = '0, rv1_data = '0;
    int            gq[$];
    int            gcq[$];

    always @(negedge clk) begin
        bit            g0, g1, x0, x1;
        logic [DW-1:0] d0, d1;
        if (!rst_n) begin
            m_busy = 1'b1; m_cnt = 0; m_last = 1'b1;
            e_en = 1'b0; e_we = 1'b0; e_addr = '0; e_wdata = '0;
            evq.delete();
        end
        g0 = !m_busy && r0_req && (!r1_req || m_last);
        g1 = !m_busy && r1_req && (!r0_req || !m_last);
        chk("r0_gnt", 64'(r0_gnt), 64'(g0));
        chk("r1_gnt", 64'(r1_gnt), 64'(g1));
        chk("init_busy", 64'(init_busy), 64'(m_busy));
        chk("mem_en", 64'(mem_en), 64'(e_en));
        chk("mem_we", 64'(mem_we), 64'(e_we));
        if (e_en || !rst_n) begin
            chk("mem_addr", 64'(mem_addr), 64'(e_addr));
            chk("mem_wdata", 64'(mem_wdata), 64'(e_wdata));
        end
        x0 = 1'b0; x1 = 1'b0; d0 = '0; d1 = '0;
        foreach (evq[i]) begin
            if (evq[i].due == cyc) begin
                if (evq[i].who == 0) begin x0 = 1'b1; d0 = evq[i].data; end
                else                 begin x1 = 1'b1; d1 = evq[i].data; end
            end
        end
        for (int i = evq.size() - 1; i >= 0; i--) if (evq[i].due <= cyc) evq.delete(i);
        chk("r0_rvalid", 64'(r0_rvalid), 64'(x0));
        chk("r1_rvalid", 64'(r1_rvalid), 64'(x1));
        if (x0) chk("r0_rdata", 64'(r0_rdata), 64'(d0));
        if (x1) chk("r1_rdata", 64'(r1_rdata), 64'(d1));

        if (mem_en && mem_we) begin
            wr_cnt++;
            wr_mask[mem_addr] = 1'b1;
            if (first_wr < 0) first_wr = int'(mem_addr);
        end
        if (r0_rvalid) begin rv0_cnt++; rv0_data = r0_rdata; rv0_cyc = cyc; end
        if (r1_rvalid) begin rv1_cnt++; rv1_data = r1_rdata; rv1_cyc = cyc; end
        if (r0_gnt) begin gq.push_back(0); gcq.push_back(cyc); end
        if (r1_gnt) begin gq.push_back(1); gcq.push_back(cyc); end

        if (rst_n) begin
            if (m_busy) begin
                e_en = 1'b1; e_we = 1'b1; e_addr = AW'(m_cnt); e_wdata = '0;
                m_tab[m_cnt] = '0;
                if (m_cnt == DEPTH - 1) begin m_busy = 1'b0; m_cnt = 0; end
                else m_cnt++;
            end else begin
                e_en = g0 || g1;
                e_we = 1'b0;
                if (g0) begin
                    e_we = r0_we; e_addr = r0_addr; e_wdata = r0_wdata; m_last = 1'b0;
                    if (r0_we) m_tab[r0_addr] = r0_wdata;
                    else evq.push_back('{cyc + 2, 0, m_tab[r0_addr]});
                end else if (g1) begin
                    e_we = r1_we; e_addr = r1_addr; e_wdata = r1_wdata; m_last = 1'b1;
                    if (r1_we) m_tab[r1_addr] = r1_wdata;
                    else evq.push_back('{cyc + 2, 1, m_tab[r1_addr]});
                end
                if (init_start) begin m_busy = 1'b1; m_cnt = 0; end
            end
        end
    end

    task automatic clear_logs();
        wr_cnt = 0; wr_mask = '0; first_wr = -1;
        rv0_cnt = 0; rv1_cnt = 0;
        gq.delete(); gcq.delete();
    endtask

    // Called at posedge+1; returns at posedge+1 after the grant cycle.
    task automatic access(input int k, input bit we, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input bit hold, output int gc);
        bit got = 1'b0;
        gc = -1;
        if (k == 0) begin r0_req = 1'b1; r0_we = we; r0_addr = a; r0_wdata = d; end
        else        begin r1_req = 1'b1; r1_we = we; r1_addr = a; r1_wdata = d; end
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if ((k == 0) ? r0_gnt : r1_gnt) begin got = 1'b1; gc = cyc; end
        end
        chk("gnt_wait", 64'(got), 64'(1));
        @(posedge clk); #1;
        if (!hold) begin
            if (k == 0) r0_req = 1'b0;
            else        r1_req = 1'b0;
        end
    endtask

    task automatic wait_clear_done(output int busy_cycles);
        bit done = 1'b0;
        busy_cycles = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (!init_busy) done = 1'b1;
            else busy_cycles++;
        end
        chk("clear_wait", 64'(done), 64'(1));
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int gc, gc2, nb;
        for (int i = 0; i < DEPTH; i++) begin bmem[i] = 32'hDEAD_0000 + i; m_tab[i] = '0; end

        // Reset state, then release and observe the clear.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 64'(init_busy), 64'(1));
        chk("rst_mem_en", 64'(mem_en), 64'(0));
        @(posedge clk); #1;
        clear_logs();
        rst_n = 1'b1;
        wait_clear_done(nb);
        chk("init_len", 64'(nb), 64'(8));
        chk("init_wr_cnt", 64'(wr_cnt), 64'(8));
        chk("init_wr_mask", 64'(wr_mask), 64'(8'hFF));
        chk("init_first_addr", 64'(first_wr), 64'(0));
        chk("init_no_gnt", 64'(gq.size()), 64'(0));

        // r1 writes addr 3, r0 reads it back.
        access(1, 1'b1, 3'd3, 32'hA5A5_A5A5, 1'b0, gc);
        access(0, 1'b0, 3'd3, '0, 1'b0, gc);
        repeat (3) @(posedge clk); #1;
        chk("rd_latency", 64'(rv0_cyc - gc), 64'(2));
        chk("rd_data", 64'(rv0_data), 64'(32'hA5A5_A5A5));

        // Both requesting continuously: alternation, one access per cycle.
        clear_logs();
        fork
            begin
                int g;
                for (int i = 0; i < 4; i++) access(0, 1'b0, AW'(i), '0, i < 3, g);
            end
            begin
                int g;
                for (int i = 0; i < 4; i++) access(1, 1'b1, AW'(4 + i), 32'h100 + i, i < 3, g);
            end
        join
        repeat (3) @(posedge clk); #1;
        chk("alt_count", 64'(gq.size()), 64'(8));
        // r0 was granted last, so r1 wins the first tie.
        if (gq.size() == 8) begin
            chk("alt_first", 64'(gq[0]), 64'(1));
            for (int i = 0; i < 7; i++) begin
                chk("alt_switch", 64'(gq[i] != gq[i+1]), 64'(1));
                chk("alt_no_bubble", 64'(gcq[i+1] - gcq[i]), 64'(1));
            end
        end
        chk("alt_rd_cnt", 64'(rv0_cnt), 64'(4));
        chk("alt_rd_last", 64'(rv0_data), 64'(32'hA5A5_A5A5));

        // init_start with a granted r1 read, then a repeated pulse mid-clear.
        clear_logs();
        r1_req = 1'b1; r1_we = 1'b0; r1_addr = 3'd5; init_start = 1'b1;
        @(negedge clk);
        chk("istart_gnt", 64'(r1_gnt), 64'(1));
        gc2 = cyc;
        @(posedge clk); #1;
        r1_req = 1'b0; init_start = 1'b0;
        repeat (3) @(posedge clk); #1;
        init_start = 1'b1;
        @(posedge clk); #1;
        init_start = 1'b0;
        wait_clear_done(nb);
        chk("istart_wr_cnt", 64'(wr_cnt), 64'(8));
        chk("istart_rv_cnt", 64'(rv1_cnt), 64'(1));
        chk("istart_rv_data", 64'(rv1_data), 64'(32'h101));
        chk("istart_rv_lat", 64'(rv1_cyc - gc2), 64'(2));

        // Reset while a read is in flight.
        clear_logs();
        access(0, 1'b0, 3'd2, '0, 1'b0, gc);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        wait_clear_done(nb);
        repeat (2) @(posedge clk); #1;
        chk("rst_abort_rv", 64'(rv0_cnt), 64'(0));
        chk("rst_first_addr", 64'(first_wr), 64'(0));
        chk("rst_wr_cnt", 64'(wr_cnt), 64'(8));

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
